// File: rtl/spmv_pkg.sv
// spmv_pkg: shared constants and types for the SpMV CSR operand sequencer.
//   - Core state encodings as reported by the SpMV core (IDLE..DONE).
//   - Matrix geometry: N rows/vector length, default nonzero capacity.
//   - Load-port target select codes and the fp16 zero constant.
//   - Sequencer FSM state type.
package spmv_pkg;

  localparam int unsigned N         = 16;
  localparam int unsigned NnzMaxDef = 64;
  localparam int unsigned RowPtrLen = N + 1;

  localparam logic [2:0] CoreIdle  = 3'b000;
  localparam logic [2:0] CoreMul   = 3'b001;
  localparam logic [2:0] CoreAdd   = 3'b010;
  localparam logic [2:0] CoreWrite = 3'b011;
  localparam logic [2:0] CoreDone  = 3'b100;

  localparam logic [1:0] SelValue  = 2'd0;
  localparam logic [1:0] SelCol    = 2'd1;
  localparam logic [1:0] SelVec    = 2'd2;
  localparam logic [1:0] SelRowPtr = 2'd3;

  localparam logic [15:0] Fp16Zero = 16'h0000;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StRun,
    StDrain,
    StFin
  } fetch_state_e;

endpackage

// File: rtl/spmv_sp_ram.sv
// spmv_sp_ram: one write port, one registered read port RAM.
//   i_clk, i_rstn          clock, async active-low reset (read register only)
//   i_wr_en/addr/data      synchronous write
//   i_rd_en/addr           read request; data appears on o_rd_data next cycle
//   o_rd_data              read register, cleared by reset, held while !i_rd_en
// The storage array itself is never cleared.
module spmv_sp_ram #(
  parameter int unsigned Depth = 64,
  parameter int unsigned Width = 16,
  parameter int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_wr_en,
  input  logic [AddrW-1:0] i_wr_addr,
  input  logic [Width-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AddrW-1:0] i_rd_addr,
  output logic [Width-1:0] o_rd_data
);

  logic [Width-1:0] r_mem [Depth];
  logic [Width-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/spmv_csr_fetch.sv
// spmv_csr_fetch: CSR operand sequencer feeding the SpMV core.
// Holds values, column indices, row_ptr[0..16] and the dense vector; on start it
// launches the core and presents one (value, x[col], count) triple per core
// MUL->ADD->WRITE iteration, following i_core_state.
//   i_clk, i_rstn        clock, async active-low reset
//   i_wr_*               load port (sel 0 value, 1 column, 2 vector, 3 row_ptr)
//   i_start              start one pass (ignored while busy)
//   i_core_state         state reported by the core
//   o_core_start         one-cycle core launch pulse
//   o_mat_value          fp16 nonzero (0 once count >= nnz)
//   o_in_vector          fp16 x[col] for the current nonzero
//   o_count              current nonzero index
//   o_row_ptr            row_ptr[i] packed at [8i+7:8i]
//   o_busy, o_done       pass in progress / end-of-pass pulse
//   o_col_err            only with SPMV_FETCH_COLCHK_EN: sticky column range error
module spmv_csr_fetch
  import spmv_pkg::*;
#(
  parameter int unsigned NNZ_MAX = NnzMaxDef
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_wr_en,
  input  logic [1:0]   i_wr_sel,
  input  logic [7:0]   i_wr_addr,
  input  logic [15:0]  i_wr_data,
  input  logic         i_start,
  input  logic [2:0]   i_core_state,
  output logic         o_core_start,
  output logic [15:0]  o_mat_value,
  output logic [15:0]  o_in_vector,
  output logic [7:0]   o_count,
  output logic [135:0] o_row_ptr,
  output logic         o_busy,
  output logic         o_done
`ifdef SPMV_FETCH_COLCHK_EN
  ,
  output logic         o_col_err
`endif
);

  localparam int unsigned ValAw = $clog2(NNZ_MAX);
  localparam int unsigned VecAw = $clog2(N);

  fetch_state_e r_state, w_state_next;
  logic [7:0]   r_count, w_count_next;
  logic [7:0]   r_row_ptr [RowPtrLen];

  logic [7:0]  w_nnz;
  logic        w_advance;
  logic [7:0]  w_idx_next;
  logic [7:0]  w_val_idx;
  logic [7:0]  w_col_idx;
  logic        w_vec_rd_en;
  logic        w_wr_idle, w_wr_val, w_wr_col, w_wr_vec, w_wr_row;
  logic [15:0] w_val_rd;
  logic [7:0]  w_col_rd;
  logic [15:0] w_vec_rd;
  logic        w_unused_bits;

  assign w_nnz      = r_row_ptr[RowPtrLen-1];
  assign w_advance  = (r_state == StRun) && (i_core_state == CoreWrite);
  assign w_idx_next = r_count + 8'd1;

  // Value read follows count, jumping ahead on the WRITE cycle so the next
  // nonzero is registered by the following MUL and then held.
  assign w_val_idx = w_advance ? w_idx_next : r_count;
  // Column read runs one nonzero ahead so the chained vector read can land on
  // the WRITE edge; in IDLE it sits on entry 0 to prime the first operands.
  assign w_col_idx = (r_state == StIdle) ? 8'd0 : w_idx_next;
  // Vector register only reloads when a new nonzero becomes current.
  assign w_vec_rd_en = (r_state == StIdle) || (r_state == StLaunch) || w_advance;

  assign w_wr_idle = i_wr_en && (r_state == StIdle);
  assign w_wr_val  = w_wr_idle && (i_wr_sel == SelValue)  && (32'(i_wr_addr) < NNZ_MAX);
  assign w_wr_col  = w_wr_idle && (i_wr_sel == SelCol)    && (32'(i_wr_addr) < NNZ_MAX);
  assign w_wr_vec  = w_wr_idle && (i_wr_sel == SelVec)    && (32'(i_wr_addr) < N);
  assign w_wr_row  = w_wr_idle && (i_wr_sel == SelRowPtr) && (32'(i_wr_addr) < RowPtrLen);

  spmv_sp_ram #(.Depth(NNZ_MAX), .Width(16)) u_val_ram (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_wr_en   (w_wr_val),
    .i_wr_addr (i_wr_addr[ValAw-1:0]),
    .i_wr_data (i_wr_data),
    .i_rd_en   (1'b1),
    .i_rd_addr (w_val_idx[ValAw-1:0]),
    .o_rd_data (w_val_rd)
  );

  spmv_sp_ram #(.Depth(NNZ_MAX), .Width(8)) u_col_ram (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_wr_en   (w_wr_col),
    .i_wr_addr (i_wr_addr[ValAw-1:0]),
    .i_wr_data (i_wr_data[7:0]),
    .i_rd_en   (1'b1),
    .i_rd_addr (w_col_idx[ValAw-1:0]),
    .o_rd_data (w_col_rd)
  );

  spmv_sp_ram #(.Depth(N), .Width(16)) u_vec_ram (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_wr_en   (w_wr_vec),
    .i_wr_addr (i_wr_addr[VecAw-1:0]),
    .i_wr_data (i_wr_data),
    .i_rd_en   (w_vec_rd_en),
    .i_rd_addr (w_col_rd[VecAw-1:0]),
    .o_rd_data (w_vec_rd)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < int'(RowPtrLen); i++) begin
        r_row_ptr[i] <= '0;
      end
    end else if (w_wr_row) begin
      r_row_ptr[i_wr_addr[4:0]] <= i_wr_data[7:0];
    end
  end

  always_comb begin
    o_row_ptr = '0;
    for (int i = 0; i < int'(RowPtrLen); i++) begin
      o_row_ptr[8*i +: 8] = r_row_ptr[i];
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= StIdle;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    o_core_start = 1'b0;
    o_done       = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_count_next = '0;
        if (i_start) begin
          w_state_next = (w_nnz != 8'd0) ? StLaunch : StFin;
        end
      end
      StLaunch: begin
        o_core_start = 1'b1;
        w_state_next = StRun;
      end
      StRun: begin
        if (i_core_state == CoreWrite) begin
          w_count_next = w_idx_next;
          if (w_idx_next == w_nnz) begin
            w_state_next = StDrain;
          end
        end
      end
      StDrain: begin
        if (i_core_state == CoreDone) begin
          w_state_next = StFin;
        end
      end
      StFin: begin
        o_done       = 1'b1;
        w_count_next = '0;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign o_busy      = (r_state != StIdle);
  assign o_count     = r_count;
  // Past the last nonzero the core may still iterate; +0 keeps its sums intact.
  assign o_mat_value = (r_count >= w_nnz) ? Fp16Zero : w_val_rd;

`ifdef SPMV_FETCH_COLCHK_EN
  logic r_vec_zero;
  logic r_col_err;
  logic w_col_oob;
  logic w_col_used;

  assign w_col_oob  = (w_col_rd >= 8'(N));
  // Only flag indices that belong to a nonzero the core will actually consume.
  assign w_col_used = (r_state == StLaunch) || (w_advance && (w_idx_next < w_nnz));

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_vec_zero <= 1'b0;
      r_col_err  <= 1'b0;
    end else begin
      if (w_vec_rd_en) begin
        r_vec_zero <= w_col_oob;
      end
      if ((r_state == StIdle) && i_start) begin
        r_col_err <= 1'b0;
      end else if (w_col_used && w_col_oob) begin
        r_col_err <= 1'b1;
      end
    end
  end

  assign o_in_vector = r_vec_zero ? Fp16Zero : w_vec_rd;
  assign o_col_err   = r_col_err;
`else
  assign o_in_vector = w_vec_rd;
`endif

  assign w_unused_bits = ^{w_col_rd, w_idx_next, w_val_idx};

endmodule

// File: tb/tb_spmv_csr_fetch.sv
// tb_spmv_csr_fetch: directed + randomized bench for spmv_csr_fetch.
// The bench plays the SpMV core (strict MUL/ADD/WRITE iterations) and keeps a
// plain-array reference of the CSR contents; expected operands are value[k] and
// x[col[k] mod N] for k < nnz, zero value beyond.
module tb_spmv_csr_fetch;
  import spmv_pkg::*;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         wr_en = 1'b0;
  logic [1:0]   wr_sel = 2'd0;
  logic [7:0]   wr_addr = 8'd0;
  logic [15:0]  wr_data = 16'd0;
  logic         start = 1'b0;
  logic [2:0]   core_state = CoreIdle;
  logic         core_start;
  logic [15:0]  mat_value;
  logic [15:0]  in_vector;
  logic [7:0]   count;
  logic [135:0] row_ptr;
  logic         busy;
  logic         done;
`ifdef SPMV_FETCH_COLCHK_EN
  logic         col_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit g_noise = 1'b0;

  logic [15:0] ref_val [64];
  logic [7:0]  ref_col [64];
  logic [15:0] ref_x   [16];
  logic [7:0]  ref_rp  [17];

  spmv_csr_fetch u_dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_wr_en      (wr_en),
    .i_wr_sel     (wr_sel),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .i_start      (start),
    .i_core_state (core_state),
    .o_core_start (core_start),
    .o_mat_value  (mat_value),
    .o_in_vector  (in_vector),
    .o_count      (count),
    .o_row_ptr    (row_ptr),
    .o_busy       (busy),
    .o_done       (done)
`ifdef SPMV_FETCH_COLCHK_EN
    ,
    .o_col_err    (col_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] fp16_int(input int v);
    int e;
    if (v == 0) return 16'h0000;
    e = 0;
    while ((v >> (e + 1)) != 0) e++;
    return {1'b0, 5'(e + 15), 10'((v << (10 - e)) & 'h3FF)};
  endfunction

  function automatic logic [135:0] ref_rp_packed();
    logic [135:0] r;
    for (int i = 0; i < 17; i++) r[8*i +: 8] = ref_rp[i];
    return r;
  endfunction

  // One clock as the core: new core state, loads/start released unless noisy.
  task automatic step(input logic [2:0] cs);
    @(posedge clk); #1;
    core_state = cs;
    start = 1'b0;
    wr_en = 1'b0;
    if (g_noise) begin
      wr_en   = 1'b1;
      wr_sel  = 2'($urandom);
      wr_addr = 8'($urandom_range(0, 20));
      wr_data = 16'($urandom);
      start   = 1'b1;
    end
    #1;
  endtask

  // Idle-time load; the reference only takes it when the address fits.
  task automatic wr(input logic [1:0] sel, input int addr, input logic [15:0] data);
    @(posedge clk); #1;
    core_state = CoreIdle;
    start   = 1'b0;
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = 8'(addr);
    wr_data = data;
    case (sel)
      SelValue:  if (addr < 64) ref_val[addr] = data;
      SelCol:    if (addr < 64) ref_col[addr] = data[7:0];
      SelVec:    if (addr < 16) ref_x[addr] = data;
      default:   if (addr < 17) ref_rp[addr] = data[7:0];
    endcase
  endtask

  task automatic write_rp();
    for (int i = 0; i < 17; i++) wr(SelRowPtr, i, {8'h00, ref_rp[i]});
  endtask

  // Random matrix with nnz nonzeros, arbitrary 8-bit column indices.
  task automatic load_random(input int nnz);
    for (int k = 0; k < nnz; k++) begin
      wr(SelValue, k, 16'($urandom));
      wr(SelCol, k, {8'h00, 8'($urandom)});
    end
    for (int i = 0; i < 16; i++) wr(SelVec, i, 16'($urandom));
    ref_rp[0] = 8'd0;
    for (int i = 1; i < 16; i++) begin
      ref_rp[i] = ref_rp[i-1] + 8'($urandom_range(0, 2));
      if (int'(ref_rp[i]) > nnz) ref_rp[i] = 8'(nnz);
    end
    ref_rp[16] = 8'(nnz);
    write_rp();
  endtask

  task automatic do_launch();
    @(posedge clk); #1;
    wr_en = 1'b0;
    core_state = CoreIdle;
    start = 1'b1;
    step(CoreIdle);
    chk("launch_core_start", core_start, 1'b1);
    chk("launch_busy", busy, 1'b1);
    chk("launch_count", count, 8'd0);
    chk("launch_value", mat_value, ref_val[0]);
  endtask

  task automatic iter(input int k, input int nnz);
    logic [2:0] cs;
    for (int p = 0; p < 3; p++) begin
      cs = (p == 0) ? CoreMul : ((p == 1) ? CoreAdd : CoreWrite);
      step(cs);
      chk($sformatf("count k%0d p%0d", k, p), count, (k < nnz) ? k : nnz);
      chk($sformatf("value k%0d p%0d", k, p), mat_value, (k < nnz) ? ref_val[k] : 16'h0000);
      if (k < nnz) begin
        chk($sformatf("vector k%0d p%0d", k, p), in_vector, ref_x[ref_col[k][3:0]]);
      end
      chk($sformatf("core_start k%0d p%0d", k, p), core_start, 1'b0);
      chk($sformatf("done k%0d p%0d", k, p), done, 1'b0);
      chk($sformatf("busy k%0d p%0d", k, p), busy, 1'b1);
    end
  endtask

  task automatic finish_pass();
    g_noise = 1'b0;
    step(CoreDone);
    chk("drain_done", done, 1'b0);
    chk("drain_busy", busy, 1'b1);
    step(CoreIdle);
    chk("fin_done", done, 1'b1);
    chk("fin_busy", busy, 1'b1);
    step(CoreIdle);
    chk("idle_done", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_count", count, 8'd0);
  endtask

  task automatic run_pass(input int nnz, input int iters);
    do_launch();
    for (int k = 0; k < iters; k++) iter(k, nnz);
    finish_pass();
  endtask

  initial begin
    int nnz;

    // Reset values
    @(posedge clk); #1;
    chk("rst_core_start", core_start, 1'b0);
    chk("rst_value", mat_value, 16'h0000);
    chk("rst_vector", in_vector, 16'h0000);
    chk("rst_count", count, 8'd0);
    chk("rst_row_ptr", row_ptr, 136'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    for (int i = 0; i < 17; i++) ref_rp[i] = 8'd0;
    @(posedge clk); #1;
    rstn = 1'b1;

    // Identity 16x16, x[i] = i
    for (int k = 0; k < 16; k++) begin
      wr(SelValue, k, 16'h3C00);
      wr(SelCol, k, 16'(k));
      wr(SelVec, k, fp16_int(k));
    end
    for (int i = 0; i < 17; i++) ref_rp[i] = 8'(i);
    write_rp();
    step(CoreIdle);
    chk("ident_row_ptr", row_ptr, ref_rp_packed());
    run_pass(16, 16);

    // Single nonzero A[3][5] = 2.0, x[5] = 1.5, plus one extra core iteration
    wr(SelValue, 0, 16'h4000);
    wr(SelCol, 0, 16'd5);
    wr(SelVec, 5, 16'h3E00);
    for (int i = 0; i < 17; i++) ref_rp[i] = (i >= 4) ? 8'd1 : 8'd0;
    write_rp();
    step(CoreIdle);
    chk("single_row_ptr", row_ptr, ref_rp_packed());
    chk("single_row_ptr4", row_ptr[39:32], 8'd1);
    run_pass(1, 2);

    // nnz = 0: no core launch, done without a pass
    for (int i = 0; i < 17; i++) ref_rp[i] = 8'd0;
    write_rp();
    @(posedge clk); #1;
    wr_en = 1'b0;
    start = 1'b1;
    step(CoreIdle);
    chk("nnz0_core_start_a", core_start, 1'b0);
    chk("nnz0_done_a", done, 1'b1);
    step(CoreIdle);
    chk("nnz0_core_start_b", core_start, 1'b0);
    chk("nnz0_done_b", done, 1'b0);
    chk("nnz0_busy_b", busy, 1'b0);

    // Out-of-range loads must not alias into the stored entries
    wr(SelValue, 0, 16'h1234);
    wr(SelCol, 0, 16'd0);
    wr(SelValue, 1, 16'h5678);
    wr(SelCol, 1, 16'd15);
    wr(SelValue, 2, 16'h9ABC);
    wr(SelCol, 2, 16'd1);
    wr(SelVec, 0, 16'h1111);
    wr(SelVec, 1, 16'h2222);
    wr(SelVec, 15, 16'h3333);
    for (int i = 0; i < 17; i++) ref_rp[i] = (i >= 8) ? 8'd3 : 8'd0;
    write_rp();
    wr(SelValue, 64, 16'hDEAD);
    wr(SelCol, 64, 16'd7);
    wr(SelVec, 16, 16'hBEEF);
    wr(SelRowPtr, 33, 16'h00AA);
    step(CoreIdle);
    chk("oor_row_ptr", row_ptr, ref_rp_packed());
    run_pass(3, 3);

    // Randomized passes; odd passes hammer loads and starts while busy
    for (int p = 0; p < 4; p++) begin
      nnz = $urandom_range(1, 24);
      load_random(nnz);
      step(CoreIdle);
      chk($sformatf("rand%0d_row_ptr", p), row_ptr, ref_rp_packed());
      do_launch();
      g_noise = (p % 2) == 1;
      for (int k = 0; k < nnz + int'($urandom_range(0, 1)); k++) iter(k, nnz);
      finish_pass();
      chk($sformatf("rand%0d_row_ptr_after", p), row_ptr, ref_rp_packed());
    end

    // Async reset mid-pass at count 7, then a full replay
    load_random(16);
    do_launch();
    for (int k = 0; k < 7; k++) iter(k, 16);
    @(posedge clk); #1;
    core_state = CoreMul;
    rstn = 1'b0;
    #1;
    chk("midrst_core_start", core_start, 1'b0);
    chk("midrst_value", mat_value, 16'h0000);
    chk("midrst_vector", in_vector, 16'h0000);
    chk("midrst_count", count, 8'd0);
    chk("midrst_row_ptr", row_ptr, 136'd0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    @(posedge clk); #1;
    chk("midrst_done_hold", done, 1'b0);
    core_state = CoreIdle;
    rstn = 1'b1;
    write_rp();
    step(CoreIdle);
    chk("replay_row_ptr", row_ptr, ref_rp_packed());
    run_pass(16, 16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
